// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq
// Description : 32x32 sequential shift-add multiplier, signed (MULT) or
//               unsigned (MULTU). One iteration per falling clock edge,
//               64-bit result presented on {hi,lo} once busy drops.
//               Optional early termination when MULT_SEQ_EARLY_TERM_EN is
//               defined: the run stops as soon as the remaining multiplier
//               bits are all zero. The result is the same either way.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sign,
    input  logic        start,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    localparam logic c_ST_IDLE = 1'b0;
    localparam logic c_ST_RUN  = 1'b1;

    logic        r_state;
    logic        w_next_state;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [4:0]  r_cnt;
    logic        r_neg;

    logic        w_accept;
    logic        w_last;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_neg_in;
    logic [63:0] w_prod;

    // Operand magnitudes; 0x80000000 negates to itself, read as unsigned 2^31
    assign w_mag_a  = (sign && a[31]) ? (~a + 32'd1) : a;
    assign w_mag_b  = (sign && b[31]) ? (~b + 32'd1) : b;
    assign w_neg_in = sign && (a[31] ^ b[31]);

    assign w_accept = (r_state == c_ST_IDLE) && start;

`ifdef MULT_SEQ_EARLY_TERM_EN
    // Stop once the multiplier left after this shift has no set bits
    assign w_last = (r_mplier[31:1] == 31'd0) || (r_cnt == 5'd31);
`else
    assign w_last = (r_cnt == 5'd31);
`endif

    // Negating a zero accumulator yields zero, so no special case is needed
    assign w_prod = r_neg ? (~r_acc + 64'd1) : r_acc;
    assign hi     = w_prod[63:32];
    assign lo     = w_prod[31:0];
    assign busy   = (r_state == c_ST_RUN);

    // State register
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: IDLE->RUN on accepted start, RUN->IDLE on final iteration
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_next_state = c_ST_RUN;
            c_ST_RUN:  if (w_last)   w_next_state = c_ST_IDLE;
            default:                 w_next_state = c_ST_IDLE;
        endcase
    end

    // Datapath: latch operands on acceptance, then one shift-add per edge
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_acc    <= 64'd0;
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
            r_cnt    <= 5'd0;
            r_neg    <= 1'b0;
        end else if (w_accept) begin
            r_acc    <= 64'd0;
            r_mcand  <= {32'd0, w_mag_a};
            r_mplier <= w_mag_b;
            r_cnt    <= 5'd0;
            r_neg    <= w_neg_in;
        end else if (r_state == c_ST_RUN) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= {r_mcand[62:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[31:1]};
            r_cnt    <= r_cnt + 5'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_seq
// Description : Self-checking bench for mult_seq. Results and busy durations
//               are compared against an arithmetic reference model.
//               Build with MULT_SEQ_EARLY_TERM_EN to exercise early exit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_seq;

    logic        clock;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic        start;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mult_seq dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .sign  (sign),
        .start (start),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference product from plain integer multiplication
    function automatic logic [63:0] ref_prod(input logic [31:0] xa, input logic [31:0] xb,
                                             input logic xs);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (xs) begin
            sa = longint'($signed(xa));
            sb = longint'($signed(xb));
            return 64'(sa * sb);
        end
        ua = {32'd0, xa};
        ub = {32'd0, xb};
        return ua * ub;
    endfunction

    // Expected number of edges busy stays high after acceptance
    function automatic int ref_iters(input logic [31:0] xb, input logic xs);
`ifdef MULT_SEQ_EARLY_TERM_EN
        longint mag;
        int     n;
        mag = xs ? longint'($signed(xb)) : longint'({32'd0, xb});
        if (mag < 0) mag = -mag;
        n = 1;
        for (int i = 0; i < 32; i++) begin
            if (mag >= (64'd1 << i)) n = i + 1;
        end
        return n;
`else
        return 32 + 0 * int'(xb[0] ^ xs);
`endif
    endfunction

    // Issue one operation; operands are scrambled right after acceptance.
    // With pulse set, start is re-asserted mid-run with new operands.
    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                          input bit pulse, output logic [31:0] ohi, output logic [31:0] olo,
                          output int ocyc);
        @(posedge clock);
        a = xa; b = xb; sign = xs; start = 1'b1;
        @(posedge clock);
        a = $urandom; b = $urandom; sign = 1'($urandom_range(0, 1));
        start = pulse;
        ocyc = 0;
        while (busy && ocyc < 100) begin
            ocyc++;
            if (ocyc == 3) start = 1'b0;
            @(posedge clock);
        end
        start = 1'b0;
        ohi = hi;
        olo = lo;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; sign = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0",
                     busy, hi, lo);
        end
        repeat (2) @(posedge clock);
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] vec_a [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'h8000_0000, 32'h8000_0000, 32'd3};
        logic [31:0] vec_b [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'h8000_0000, 32'd1, 32'd5};
        logic        vec_s [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] exp_v [6] = '{64'h0000_0000_0000_0001, 64'hFFFF_FFFE_0000_0001,
                                   64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000,
                                   64'hFFFF_FFFF_8000_0000, 64'd15};
        logic [31:0] rh;
        logic [31:0] rl;
        int          cyc;
        for (int i = 0; i < 6; i++) begin
            run_op(vec_a[i], vec_b[i], vec_s[i], 1'b0, rh, rl, cyc);
            total++;
            if ({rh, rl} !== exp_v[i]) begin
                bad++;
                $display("FAIL directed_%0d: got %h_%h expected %h", i, rh, rl, exp_v[i]);
            end
            total++;
            if (cyc != ref_iters(vec_b[i], vec_s[i])) begin
                bad++;
                $display("FAIL directed_busy_%0d: busy edges %0d expected %0d", i, cyc,
                         ref_iters(vec_b[i], vec_s[i]));
            end
        end
    endtask

    task automatic test_zero_and_ignore;
        logic [31:0] rh;
        logic [31:0] rl;
        int          cyc;
        // Zero product with negative polarity, new start pulsed mid-run
        run_op(32'd0, 32'hFFFF_FFFB, 1'b1, 1'b1, rh, rl, cyc);
        total++;
        if (rh !== 32'd0 || rl !== 32'd0 || cyc != ref_iters(32'hFFFF_FFFB, 1'b1)) begin
            bad++;
            $display("FAIL zero_neg_ignore: got %h_%h cyc=%0d expected 0_0 cyc=%0d",
                     rh, rl, cyc, ref_iters(32'hFFFF_FFFB, 1'b1));
        end
        // Zero multiplier: shortest run under early termination
        run_op(32'h1234_5678, 32'd0, 1'b0, 1'b0, rh, rl, cyc);
        total++;
        if ({rh, rl} !== 64'd0 || cyc != ref_iters(32'd0, 1'b0)) begin
            bad++;
            $display("FAIL zero_mult: got %h_%h cyc=%0d expected 0 cyc=%0d",
                     rh, rl, cyc, ref_iters(32'd0, 1'b0));
        end
    endtask

    task automatic test_hold;
        logic [31:0] rh;
        logic [31:0] rl;
        int          cyc;
        logic [63:0] exp_p;
        run_op(32'hFFFF_FFF9, 32'd1000, 1'b1, 1'b0, rh, rl, cyc);
        exp_p = ref_prod(32'hFFFF_FFF9, 32'd1000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom; sign = 1'($urandom_range(0, 1));
            @(posedge clock);
            total++;
            if ({hi, lo} !== exp_p || busy !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d: got %h_%h busy=%b expected %h busy=0",
                         i, hi, lo, busy, exp_p);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rh;
        logic [31:0] rl;
        int          cyc;
        @(posedge clock);
        a = 32'hFFFF_0001; b = 32'hFFFF_FFFF; sign = 1'b0; start = 1'b1;
        @(posedge clock);
        start = 1'b0;
        repeat (10) @(posedge clock);
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0",
                     busy, hi, lo);
        end
        @(posedge clock);
        reset = 1'b0;
        run_op(32'd7, 32'd6, 1'b0, 1'b0, rh, rl, cyc);
        total++;
        if (rh !== 32'd0 || rl !== 32'd42 || cyc != ref_iters(32'd6, 1'b0)) begin
            bad++;
            $display("FAIL after_reset_7x6: got %h_%h cyc=%0d expected 0_2a cyc=%0d",
                     rh, rl, cyc, ref_iters(32'd6, 1'b0));
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        @(posedge clock);
        a = 32'd1234; b = 32'd5678; sign = 1'b0; start = 1'b1;
        @(posedge clock);
        a = 32'hFFFF_FFFD; b = 32'd9; sign = 1'b1;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clock);
        end
        total++;
        if (busy !== 1'b0 || {hi, lo} !== ref_prod(32'd1234, 32'd5678, 1'b0)) begin
            bad++;
            $display("FAIL b2b_first: busy=%b got %h_%h expected busy=0 %h",
                     busy, hi, lo, ref_prod(32'd1234, 32'd5678, 1'b0));
        end
        @(posedge clock);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: busy=%b expected 1", busy);
        end
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clock);
        end
        total++;
        if ({hi, lo} !== ref_prod(32'hFFFF_FFFD, 32'd9, 1'b1)
            || cyc != ref_iters(32'd9, 1'b1)) begin
            bad++;
            $display("FAIL b2b_second: got %h_%h cyc=%0d expected %h cyc=%0d", hi, lo,
                     cyc, ref_prod(32'hFFFF_FFFD, 32'd9, 1'b1), ref_iters(32'd9, 1'b1));
        end
    endtask

    task automatic test_random;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [31:0] rh;
        logic [31:0] rl;
        int          cyc;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 1) rb = rb >> $urandom_range(1, 31);
            if (i % 7 == 2) ra = 32'h8000_0000;
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, 1'(i % 3 == 0), rh, rl, cyc);
            total++;
            if ({rh, rl} !== ref_prod(ra, rb, rs) || cyc != ref_iters(rb, rs)) begin
                bad++;
                $display("FAIL random_%0d: a=%h b=%h s=%b got %h_%h cyc=%0d expected %h cyc=%0d",
                         i, ra, rb, rs, rh, rl, cyc, ref_prod(ra, rb, rs), ref_iters(rb, rs));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_and_ignore();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on the falling edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears state immediately.
REQ-003 SHALL have port: a  input  32  multiplicand.
REQ-004 SHALL have port: b  input  32  multiplier.
REQ-005 SHALL have port: sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU).
REQ-006 SHALL have port: start  input  1  request; sampled only while busy=0.
REQ-007 SHALL have port: hi  output  32  product bits [63:32].
REQ-008 SHALL have port: lo  output  32  product bits [31:0].
REQ-009 SHALL have port: busy  output  1  registered; high while an operation is in progress.

Function
REQ-010 SHALL accept an operation on a falling edge where start=1 and busy=0, latching a, b and sign; busy goes high at that edge.
REQ-011 SHALL ignore start, a, b and sign while busy=1; a, b and sign need not be held after acceptance.
REQ-012 SHALL, with sign=1, take magnitudes (two's complement of negative operands) and record result polarity = a[31] XOR b[31]; with sign=0, use operands unchanged, polarity positive.
REQ-013 SHALL treat magnitude 0x80000000 as unsigned 2^31 (no overflow).
REQ-014 SHALL iterate shift-add: 64-bit accumulator; 64-bit multiplicand shifted left 1 per cycle; 32-bit multiplier shifted right 1 per cycle; add multiplicand when multiplier LSB=1.
REQ-015 SHALL use a 5-bit iteration counter, reset to 0 on acceptance, incremented each busy cycle.
REQ-016 SHALL perform exactly 32 iterations on the 32 falling edges after acceptance; busy falls at the 32nd (baseline latency 33 edges, acceptance included).
REQ-017 SHALL present {hi,lo} = accumulator, negated (two's complement, 64-bit) when polarity negative; hi/lo are undefined while busy=1.
REQ-018 SHALL hold hi/lo stable while busy=0 until the next accepted operation, independent of a, b, sign changes.
REQ-019 SHALL produce 0 (not 0xFFFF...) for a zero product with negative polarity.
REQ-020 SHALL, when start=1 at the same edge busy falls, not accept it; acceptance occurs no earlier than the following edge.
REQ-021 SHALL implement states IDLE (busy=0) and RUN (busy=1) only: IDLE->RUN on accepted start; RUN->IDLE on final iteration; reset forces IDLE.

Reset
REQ-022 SHALL, on reset=1, asynchronously clear busy, counter, accumulator, multiplicand, multiplier and polarity, so hi=0 and lo=0.
REQ-023 SHALL abort any in-progress operation on reset with no result retained; the first edge after reset deasserts may accept start.

Configuration
REQ-024 SHALL support macro MULT_SEQ_EARLY_TERM_EN: when defined, RUN ends at the iteration after which the shifted multiplier equals 0 (iterations = 1 + index of MSB of |b|; minimum 1 when |b|=0); when undefined, exactly 32 iterations always.
REQ-025 SHALL produce identical hi/lo results with and without MULT_SEQ_EARLY_TERM_EN; only busy duration differs.

Verification
REQ-026 SHALL cover: sign=1, a=-1, b=-1 -> after 32 iterations hi=0x00000000, lo=0x00000001, busy high 32 edges after acceptance.
REQ-027 SHALL cover: sign=0, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; same operands with sign=1 -> hi=0, lo=1.
REQ-028 SHALL cover: sign=1, a=b=0x80000000 -> hi=0x40000000, lo=0; sign=1, a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
REQ-029 SHALL cover: sign=1, a=0, b=-5 -> hi=lo=0; start pulsed mid-operation with new operands -> ignored, first result unchanged.
REQ-030 SHALL cover: reset asserted at iteration 10 -> busy=0, hi=lo=0 immediately; new operation 7x6 afterwards -> lo=42, hi=0.
REQ-031 SHALL cover, with MULT_SEQ_EARLY_TERM_EN: sign=0, a=3, b=5 -> busy high 3 edges, lo=15; b=0 -> busy high 1 edge, lo=0.
